// File: rtl/jtkunio_mbox.sv
// Bidirectional main CPU <-> protection MCU mailbox: two independent FIFOs
// with registered heads, polled status bits, MCU interrupt and sticky overflow flags.

module jtkunio_mbox_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 1,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          we,
    input  logic          re,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          ovf
);
    // Storage is sized to the pointer range so DEPTH=1 still has a legal 1-bit index.
    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          ovf_q, ovf_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = dout_q;
    assign ovf   = ovf_q;

    always_comb begin
        do_pop   = re && !empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        do_push  = we && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = (DEPTH == 1) ? '0 : wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = (DEPTH == 1) ? '0 : rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (we && !do_push) ovf_d = 1'b1;
            // The new head is the incoming word when it lands at the head slot this edge.
            if ((do_push || do_pop) && count_d != '0)
                dout_d = (do_push && rd_ptr_d == wr_ptr_q) ? din : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

module jtkunio_mbox #(
    parameter int DW    = 8,
    parameter int DEPTH = 1,
    parameter int AW    = ($clog2(DEPTH) > 0) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          main_we,
    input  logic          main_re,
    input  logic [DW-1:0] main_din,
    output logic [DW-1:0] main_dout,
    output logic [1:0]    main_st,
    output logic          main_ovf,
    input  logic          mcu_we,
    input  logic          mcu_re,
    input  logic [DW-1:0] mcu_din,
    output logic [DW-1:0] mcu_dout,
    output logic          mcu_irq,
    output logic          mcu_ovf
);
    // Handshake: every *_we/*_re high on a clk edge is exactly one operation; there is
    // no ready back-pressure, callers poll main_st/mcu_irq and overflow is flagged, not stalled.
    logic m2s_full, m2s_empty, s2m_full, s2m_empty;

    jtkunio_mbox_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_m2s (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .we    (main_we),
        .re    (mcu_re),
        .din   (main_din),
        .dout  (mcu_dout),
        .full  (m2s_full),
        .empty (m2s_empty),
        .ovf   (main_ovf)
    );

    jtkunio_mbox_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_s2m (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .we    (mcu_we),
        .re    (main_re),
        .din   (mcu_din),
        .dout  (main_dout),
        .full  (s2m_full),
        .empty (s2m_empty),
        .ovf   (mcu_ovf)
    );

    // Status bits come straight from the count registers, so they change on the same edge.
    assign main_st = {~s2m_empty, ~m2s_full};
    assign mcu_irq = ~m2s_empty;
endmodule

// File: tb/tb_jtkunio_mbox.sv
// Scoreboard bench for jtkunio_mbox: three instances (DEPTH 1, 4, 8) share stimulus and are
// checked each cycle against a queue-based model of the mailbox.

module tb_jtkunio_mbox;
    localparam int N  = 3;
    localparam int EW = 21;

    typedef struct packed {
        logic [7:0] md;
        logic [7:0] sd;
        logic [1:0] st;
        logic       irq;
        logic       movf;
        logic       sovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       main_we = 1'b0, main_re = 1'b0, mcu_we = 1'b0, mcu_re = 1'b0;
    logic [7:0] main_din = '0, mcu_din = '0;

    logic [7:0] main_dout_w [N];
    logic [7:0] mcu_dout_w  [N];
    logic [1:0] main_st_w   [N];
    logic       main_ovf_w  [N];
    logic       mcu_irq_w   [N];
    logic       mcu_ovf_w   [N];

    int errors = 0;
    int checks = 0;

    logic [N*EW-1:0] exp_q [$];

    // reference model state
    logic [7:0] m2s_m [N][$];
    logic [7:0] s2m_m [N][$];
    logic [7:0] main_dout_m [N];
    logic [7:0] mcu_dout_m  [N];
    logic       movf_m [N];
    logic       sovf_m [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        jtkunio_mbox #(.DW(8), .DEPTH(g == 0 ? 1 : (g == 1 ? 4 : 8))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .main_we   (main_we),
            .main_re   (main_re),
            .main_din  (main_din),
            .main_dout (main_dout_w[g]),
            .main_st   (main_st_w[g]),
            .main_ovf  (main_ovf_w[g]),
            .mcu_we    (mcu_we),
            .mcu_re    (mcu_re),
            .mcu_din   (mcu_din),
            .mcu_dout  (mcu_dout_w[g]),
            .mcu_irq   (mcu_irq_w[g]),
            .mcu_ovf   (mcu_ovf_w[g])
        );
    end

    function automatic int dep(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
    endfunction

    task automatic chk(input string nm, input int i, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s depth=%0d got=%h exp=%h t=%0t", nm, dep(i), got, exp, $time);
        end
    endtask

    task automatic chk_reset();
        for (int i = 0; i < N; i++) begin
            chk("rst_main_dout", i, main_dout_w[i], 8'h00);
            chk("rst_mcu_dout", i, mcu_dout_w[i], 8'h00);
            chk("rst_main_st", i, {6'd0, main_st_w[i]}, 8'h01);
            chk("rst_mcu_irq", i, {7'd0, mcu_irq_w[i]}, 8'h00);
            chk("rst_main_ovf", i, {7'd0, main_ovf_w[i]}, 8'h00);
            chk("rst_mcu_ovf", i, {7'd0, mcu_ovf_w[i]}, 8'h00);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m2s_m[i].delete();
            s2m_m[i].delete();
            main_dout_m[i] = '0;
            mcu_dout_m[i]  = '0;
            movf_m[i] = 1'b0;
            sovf_m[i] = 1'b0;
        end
    endtask

    // One clock of stimulus: inputs change on negedge, the model predicts the state
    // after the following posedge and queues it for the monitor.
    task automatic drive(input logic fl, input logic mwe, input logic mre, input logic [7:0] md,
                         input logic swe, input logic sre, input logic [7:0] sd);
        logic [N*EW-1:0] v;
        exp_t            e;
        bit              pop, push;
        @(negedge clk);
        flush = fl; main_we = mwe; main_re = mre; main_din = md;
        mcu_we = swe; mcu_re = sre; mcu_din = sd;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (fl) begin
                m2s_m[i].delete();
                s2m_m[i].delete();
                movf_m[i] = 1'b0;
                sovf_m[i] = 1'b0;
            end else begin
                pop  = sre && m2s_m[i].size() > 0;
                push = mwe && (m2s_m[i].size() < dep(i) || pop);
                if (mwe && !push) movf_m[i] = 1'b1;
                if (pop) void'(m2s_m[i].pop_front());
                if (push) m2s_m[i].push_back(md);
                if ((pop || push) && m2s_m[i].size() > 0) mcu_dout_m[i] = m2s_m[i][0];
                pop  = mre && s2m_m[i].size() > 0;
                push = swe && (s2m_m[i].size() < dep(i) || pop);
                if (swe && !push) sovf_m[i] = 1'b1;
                if (pop) void'(s2m_m[i].pop_front());
                if (push) s2m_m[i].push_back(sd);
                if ((pop || push) && s2m_m[i].size() > 0) main_dout_m[i] = s2m_m[i][0];
            end
            e.md   = main_dout_m[i];
            e.sd   = mcu_dout_m[i];
            e.st   = {s2m_m[i].size() != 0, m2s_m[i].size() < dep(i)};
            e.irq  = m2s_m[i].size() != 0;
            e.movf = movf_m[i];
            e.sovf = sovf_m[i];
            v[i*EW +: EW] = e;
        end
        exp_q.push_back(v);
    endtask

    task automatic idle_inputs();
        flush = 0; main_we = 0; main_re = 0; mcu_we = 0; mcu_re = 0;
    endtask

    // monitor: compare the state after each edge that has a queued prediction
    always @(posedge clk) begin
        logic [N*EW-1:0] v;
        exp_t            e;
        #1;
        if (!rst && exp_q.size() > 0) begin
            v = exp_q.pop_front();
            for (int i = 0; i < N; i++) begin
                e = v[i*EW +: EW];
                chk("main_dout", i, main_dout_w[i], e.md);
                chk("mcu_dout", i, mcu_dout_w[i], e.sd);
                chk("main_st", i, {6'd0, main_st_w[i]}, {6'd0, e.st});
                chk("mcu_irq", i, {7'd0, mcu_irq_w[i]}, {7'd0, e.irq});
                chk("main_ovf", i, {7'd0, main_ovf_w[i]}, {7'd0, e.movf});
                chk("mcu_ovf", i, {7'd0, mcu_ovf_w[i]}, {7'd0, e.sovf});
            end
        end
    end

    initial begin
        logic [7:0] seq [5];
        int         pw, pr;
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44; seq[4] = 8'h55;
        model_reset();
        #2;
        chk_reset();
        @(negedge clk);
        rst = 1'b0;

        // single-byte handshake, then release
        drive(0, 1, 0, 8'hA5, 0, 0, 8'h00);
        drive(0, 0, 0, 8'h00, 0, 1, 8'h00);
        drive(1, 0, 0, 8'h00, 0, 0, 8'h00);

        // fill M2S past capacity, then drain
        for (int k = 0; k < 5; k++) drive(0, 1, 0, seq[k], 0, 0, 8'h00);
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 8'h00, 0, 1, 8'h00);
        drive(1, 0, 0, 8'h00, 0, 0, 8'h00);

        // S2M push+pop with one entry held, then pops on empty, then push+pop on empty
        drive(0, 0, 0, 8'h00, 1, 0, 8'h7E);
        drive(0, 0, 1, 8'h00, 1, 0, 8'h9C);
        drive(0, 0, 1, 8'h00, 0, 0, 8'h00);
        drive(0, 0, 1, 8'h00, 0, 0, 8'h00);
        drive(0, 0, 1, 8'h00, 1, 0, 8'h3C);
        drive(0, 0, 1, 8'h00, 0, 0, 8'h00);

        // full M2S with overflow, flush wins over same-cycle push
        for (int k = 0; k < 5; k++) drive(0, 1, 0, 8'hC0 + 8'(k), 0, 0, 8'h00);
        drive(1, 1, 0, 8'hEE, 0, 0, 8'h00);
        drive(0, 0, 0, 8'h00, 0, 1, 8'h00);

        // async reset mid-burst
        for (int k = 0; k < 5; k++) drive(0, 1, 0, 8'h60 + 8'(k), 1, 0, 8'h70 + 8'(k));
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle_inputs();
        #1;
        chk_reset();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 1, 8'h00, 0, 1, 8'h00);
        drive(0, 1, 0, 8'h42, 1, 0, 8'h24);
        drive(0, 0, 1, 8'h00, 0, 1, 8'h00);

        // randomized traffic with alternating fill/drain bias and rare flushes
        for (int k = 0; k < 1600; k++) begin
            pw = ((k / 64) % 2 == 0) ? 70 : 30;
            pr = 100 - pw;
            drive($urandom_range(0, 59) == 0,
                  $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom),
                  $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom));
        end

        drive(0, 0, 0, 8'h00, 0, 0, 8'h00);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
